sd_xfer_seq: RTL and testbench

- Multi-sector SD transfer sequencer between the CPU port block and the SD card engine.
- Accepts one job: start LBA, sector count and direction. Issues one SD command per sector, waits for completion, advances the LBA and reports final status.
- Handles SD-busy gating, per-sector timeout, abort, and optional retry on card error.
- Per-sector strobes let the sector-buffer logic step its pointer.

---
 rtl/sd_xfer_seq.sv | 202 ++++++++++++++++++++
 tb/tb_sd_xfer_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_xfer_seq.sv
// sd_xfer_seq: multi-sector SD transfer sequencer.
// Takes one job (start LBA, sector count, direction) and issues one SD command
// per sector. It gates each command on sd_busy and times out a sector that
// never completes. Abort stops the job once the current sector is finished.
// Optional build macro SD_XFER_RETRY_EN re-issues a sector that returns a card
// error, up to RETRIES extra attempts.
module sd_xfer_seq #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 2500000,
  parameter int unsigned RETRIES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_rw,
  input  logic [31:0]      cmd_lba,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       status,
  output logic [31:0]      cur_lba,
  output logic [CNT_W-1:0] remain,
  output logic             sect_start,
  output logic             sect_done,
  output logic             sd_command,
  output logic             sd_rw,
  output logic [31:0]      sd_lba,
  input  logic             sd_busy,
  input  logic             sd_done,
  input  logic [3:0]       sd_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  ST_ABORT   = 4'hE;
  localparam logic [3:0]  ST_TIMEOUT = 4'hF;

  state_t        state, state_next;
  logic          abort_l;
  logic          abort_any;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          set_status;
  logic [3:0]    fin_status;
  logic          sect_ok;

`ifdef SD_XFER_RETRY_EN
  localparam int unsigned AW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  logic [AW-1:0] attempts;
  logic          retry;
`endif

  assign abort_any = abort_l | abort;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

  // Outputs that follow directly from the current state.
  always_comb begin
    busy       = (state != S_IDLE) && (state != S_FIN);
    done       = (state == S_FIN);
    sd_command = (state == S_ISSUE);
    sect_start = (state == S_ISSUE);
  end

  // Next-state decode and end-of-job status selection.
  always_comb begin
    state_next = state;
    set_status = 1'b0;
    fin_status = '0;
    sect_ok    = 1'b0;
`ifdef SD_XFER_RETRY_EN
    retry      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          state_next = (cmd_count == '0) ? S_FIN : S_ARM;
        end
      end
      S_ARM: begin
        if (abort_any) begin
          state_next = S_FIN;
          set_status = 1'b1;
          fin_status = ST_ABORT;
        end else if (!sd_busy) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // sd_done has priority over a timeout in the same cycle.
        if (sd_done) begin
          if (sd_error == '0) begin
            sect_ok    = 1'b1;
            state_next = (remain == CNT_W'(1)) ? S_FIN : S_NEXT;
          end else begin
            state_next = S_FIN;
            set_status = 1'b1;
            fin_status = sd_error;
`ifdef SD_XFER_RETRY_EN
            if (abort_any) begin
              fin_status = ST_ABORT;
            end else if (attempts < AW'(RETRIES)) begin
              retry      = 1'b1;
              state_next = S_ARM;
              set_status = 1'b0;
            end
`endif
          end
        end else if (tmo_hit) begin
          state_next = S_FIN;
          set_status = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      S_NEXT: begin
        if (abort_any) begin
          state_next = S_FIN;
          set_status = 1'b1;
          fin_status = ST_ABORT;
        end else begin
          state_next = S_ARM;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register and job bookkeeping (address, count, abort, timeout).
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      abort_l   <= 1'b0;
      tmo_cnt   <= '0;
      status    <= '0;
      cur_lba   <= '0;
      remain    <= '0;
      sd_rw     <= 1'b0;
      sd_lba    <= '0;
      sect_done <= 1'b0;
`ifdef SD_XFER_RETRY_EN
      attempts  <= '0;
`endif
    end else begin
      state     <= state_next;
      sect_done <= sect_ok;

      if (state == S_IDLE && cmd_start) begin
        sd_rw    <= cmd_rw;
        cur_lba  <= cmd_lba;
        sd_lba   <= cmd_lba;
        remain   <= cmd_count;
        status   <= '0;
        abort_l  <= 1'b0;
`ifdef SD_XFER_RETRY_EN
        attempts <= '0;
`endif
      end

      if (state == S_FIN) begin
        abort_l <= 1'b0;
      end else if (state != S_IDLE && abort) begin
        abort_l <= 1'b1;
      end

      if (state == S_ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (set_status) begin
        status <= fin_status;
      end

      if (sect_ok) begin
        remain   <= remain - 1'b1;
        cur_lba  <= cur_lba + 32'd1;
        sd_lba   <= cur_lba + 32'd1;
`ifdef SD_XFER_RETRY_EN
        attempts <= '0;
`endif
      end

`ifdef SD_XFER_RETRY_EN
      if (retry) begin
        attempts <= attempts + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sd_xfer_seq.sv
// Scoreboard bench for sd_xfer_seq: expected command LBAs and per-job results
// are queued when each job is started and compared as the DUT produces them.
module tb_sd_xfer_seq;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMO     = 40;
  localparam int unsigned RETRIES = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_start = 1'b0;
  logic             cmd_rw = 1'b0;
  logic [31:0]      cmd_lba = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;
  logic             busy, done, sect_start, sect_done, sd_command, sd_rw;
  logic [3:0]       status;
  logic [31:0]      cur_lba, sd_lba;
  logic [CNT_W-1:0] remain;
  logic             sd_busy = 1'b0;
  logic             sd_done = 1'b0;
  logic [3:0]       sd_error = '0;

  sd_xfer_seq #(.CNT_W(CNT_W), .TIMEOUT(TMO), .RETRIES(RETRIES)) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_rw(cmd_rw),
    .cmd_lba(cmd_lba), .cmd_count(cmd_count), .abort(abort), .busy(busy),
    .done(done), .status(status), .cur_lba(cur_lba), .remain(remain),
    .sect_start(sect_start), .sect_done(sect_done), .sd_command(sd_command),
    .sd_rw(sd_rw), .sd_lba(sd_lba), .sd_busy(sd_busy), .sd_done(sd_done),
    .sd_error(sd_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  status;
    logic [7:0]  remain;
    logic [31:0] lba;
    int          ncmd;
    int          nsect;
  } job_t;

  job_t        job_q[$];
  logic [31:0] lba_q[$];
  logic [3:0]  err_q[$];
  bit          withhold = 0;
  int          resp_delay = 20;
  logic        exp_rw = 1'b0;
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, start_cyc = 0, done_cyc = 0, first_cmd_cyc = 0;
  int          job_cmds = 0, job_sects = 0, jobs_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each command and each done.
  always @(negedge clock) begin
    job_t e;
    if (!reset) begin
      if (sect_done) job_sects++;
      if (sd_command) begin
        if (job_cmds == 0) first_cmd_cyc = cyc;
        job_cmds++;
        check("sect_start", sect_start, 1);
        check("sd_rw", sd_rw, exp_rw);
        if (lba_q.size() > 0) check("sd_lba", sd_lba, lba_q.pop_front());
        else check("unexpected_cmd", sd_command, 0);
      end
      if (done) begin
        done_cyc = cyc;
        if (job_q.size() > 0) begin
          e = job_q.pop_front();
          check("status", status, e.status);
          check("remain", remain, e.remain);
          check("cur_lba", cur_lba, e.lba);
          check("busy_at_done", busy, 0);
          check("cmd_count", job_cmds, e.ncmd);
          check("sect_count", job_sects, e.nsect);
          check("missing_cmds", lba_q.size(), 0);
        end else begin
          check("unexpected_done", done, 0);
        end
        lba_q.delete();
        job_cmds  = 0;
        job_sects = 0;
        jobs_done++;
      end
    end
  end

  // SD engine model: answers each command after resp_delay cycles.
  initial begin
    logic [3:0] ec;
    forever begin
      @(negedge clock);
      if (sd_command && !withhold) begin
        ec = (err_q.size() > 0) ? err_q.pop_front() : 4'h0;
        repeat (resp_delay) @(posedge clock);
        #1 sd_done = 1'b1; sd_error = ec;
        @(posedge clock);
        #1 sd_done = 1'b0; sd_error = '0;
      end
    end
  end

  task automatic push_job(input logic [3:0] st, input logic [7:0] rem,
                          input logic [31:0] lba, input int nc, input int ns);
    job_t j;
    j.status = st; j.remain = rem; j.lba = lba; j.ncmd = nc; j.nsect = ns;
    job_q.push_back(j);
  endtask

  task automatic start_job(input logic rw, input logic [31:0] lba, input logic [7:0] cnt);
    cmd_rw = rw; cmd_lba = lba; cmd_count = cnt; cmd_start = 1'b1;
    exp_rw = rw; start_cyc = cyc;
    @(posedge clock); #1 cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int target;
    bit ok;
    target = jobs_done + 1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (jobs_done >= target) begin ok = 1; break; end
    end
    check({tag, "_done_seen"}, ok, 1);
    repeat (3) @(posedge clock); #1;
  endtask

  task automatic wait_first_cmd();
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (job_cmds > 0) break;
    end
  endtask

  initial begin
    int fall_cyc;
    repeat (2) @(posedge clock); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_cur_lba", cur_lba, 0);
    check("rst_remain", remain, 0);
    check("rst_sd_command", sd_command, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_sect_done", sect_done, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;

    // Normal read of three sectors, with a stray start while busy.
    lba_q = '{32'h10, 32'h11, 32'h12};
    push_job(4'h0, 8'd0, 32'h13, 3, 3);
    start_job(1'b0, 32'h10, 8'd3);
    repeat (4) @(posedge clock); #1;
    cmd_lba = 32'h500; cmd_count = 8'd1; cmd_start = 1'b1;
    @(posedge clock); #1 cmd_start = 1'b0;
    wait_done("read");
    check("issue_latency", first_cmd_cyc - start_cyc, 2);

    // Busy gating: first command the cycle after sd_busy drops.
    lba_q = '{32'h20, 32'h21};
    push_job(4'h0, 8'd0, 32'h22, 2, 2);
    sd_busy = 1'b1;
    start_job(1'b0, 32'h20, 8'd2);
    repeat (50) @(posedge clock); #1;
    sd_busy = 1'b0; fall_cyc = cyc;
    wait_done("busy");
    check("busy_gate_latency", first_cmd_cyc - fall_cyc, 1);

    // LBA wrap on a write job.
    lba_q = '{32'hFFFF_FFFF, 32'h0};
    push_job(4'h0, 8'd0, 32'h1, 2, 2);
    start_job(1'b1, 32'hFFFF_FFFF, 8'd2);
    wait_done("wrap");

    // Empty job: done the next cycle, no command.
    push_job(4'h0, 8'd0, 32'h77, 0, 0);
    start_job(1'b0, 32'h77, 8'd0);
    wait_done("empty");
    check("empty_latency", done_cyc - start_cyc, 1);

    // Card error on the second sector ends the job.
    err_q = '{4'h0, 4'h3};
    lba_q = '{32'h40, 32'h41};
    push_job(4'h3, 8'd3, 32'h41, 2, 1);
    start_job(1'b0, 32'h40, 8'd4);
    wait_done("error");

    // Abort during the first sector: that sector still completes.
    err_q.delete();
    lba_q = '{32'h60};
    push_job(4'hE, 8'd4, 32'h61, 1, 1);
    start_job(1'b0, 32'h60, 8'd5);
    wait_first_cmd();
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    wait_done("abort");

    // Abort while still waiting for sd_busy: no command at all.
    push_job(4'hE, 8'd3, 32'h90, 0, 0);
    sd_busy = 1'b1;
    start_job(1'b0, 32'h90, 8'd3);
    repeat (3) @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    wait_done("abort_arm");
    sd_busy = 1'b0;

    // Timeout when sd_done never arrives.
    withhold = 1;
    lba_q = '{32'h80};
    push_job(4'hF, 8'd2, 32'h80, 1, 0);
    start_job(1'b0, 32'h80, 8'd2);
    wait_done("timeout");
    check("timeout_latency", done_cyc - first_cmd_cyc, TMO + 1);
    withhold = 0;

`ifdef SD_XFER_RETRY_EN
    // Two errors then success: same LBA issued three times.
    err_q = '{4'h2, 4'h2, 4'h0};
    lba_q = '{32'h100, 32'h100, 32'h100};
    push_job(4'h0, 8'd0, 32'h101, 3, 1);
    start_job(1'b0, 32'h100, 8'd1);
    wait_done("retry_ok");

    // Error on every attempt: four commands, then the last error code.
    err_q = '{4'h2, 4'h2, 4'h2, 4'h2};
    lba_q = '{32'h200, 32'h200, 32'h200, 32'h200};
    push_job(4'h2, 8'd1, 32'h200, 4, 0);
    start_job(1'b0, 32'h200, 8'd1);
    wait_done("retry_fail");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
